// File: rtl/mac_table_ctrl.sv
// Per-frame MAC table sequencer: captures DA/SA from the byte stream, looks up DA,
// learns SA, and reports the forwarding result three cycles after the last header byte.
module mac_table_ctrl #(
  parameter int unsigned pDATA_WIDTH = 8,
  parameter int unsigned pMAC_WIDTH  = 48,
  parameter int unsigned pSIZE_OUT   = 14,
  parameter int unsigned pPORT_W     = 3
) (
  input  logic                            iclk,
  input  logic                            irst,
  input  logic [pDATA_WIDTH-1:0]          idata,
  input  logic                            ivalid,
  input  logic                            isop,
  input  logic                            ieop,
  input  logic [pPORT_W-1:0]              iport,
  output logic [pSIZE_OUT-1:0]            omem_addr,
  output logic                            omem_re,
  output logic                            omem_we,
  output logic [pMAC_WIDTH+pPORT_W:0]     omem_wdata,
  input  logic [pMAC_WIDTH+pPORT_W:0]     imem_rdata,
  output logic                            ores_valid,
  output logic                            ohit,
  output logic [pPORT_W-1:0]              odst_port,
  output logic                            obusy,
  output logic                            ooverrun
);

  localparam int unsigned MacBytes = pMAC_WIDTH / pDATA_WIDTH;
  localparam int unsigned LastByte = 2 * MacBytes - 1;
  localparam int unsigned CntW     = $clog2(2 * MacBytes);
  localparam int unsigned GroupBit = pMAC_WIDTH - 8;
  localparam int unsigned ValidBit = pMAC_WIDTH + pPORT_W;

  typedef enum logic [2:0] {StIdle, StCollect, StLookup, StLearn, StResult} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [pMAC_WIDTH-1:0]   da_q;
  logic [pMAC_WIDTH-1:0]   sa_q;
  logic [pPORT_W-1:0]      port_q;
  logic                    hit;

  // Group DA is never looked up, so whatever is on the read bus must not count.
  assign hit = imem_rdata[ValidBit] && (imem_rdata[pPORT_W +: pMAC_WIDTH] == da_q)
               && !da_q[GroupBit];

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      da_q       <= '0;
      sa_q       <= '0;
      port_q     <= '0;
      omem_addr  <= '0;
      omem_re    <= 1'b0;
      omem_we    <= 1'b0;
      omem_wdata <= '0;
      ores_valid <= 1'b0;
      ohit       <= 1'b0;
      odst_port  <= '0;
      obusy      <= 1'b0;
      ooverrun   <= 1'b0;
    end else begin
      omem_re    <= 1'b0;
      omem_we    <= 1'b0;
      omem_addr  <= '0;
      omem_wdata <= '0;
      ores_valid <= 1'b0;
      ohit       <= 1'b0;
      odst_port  <= '0;
      // A frame starting while busy is dropped; its later bytes carry no isop and
      // are therefore ignored by StIdle.
      ooverrun   <= obusy && ivalid && isop;
      case (state_q)
        StIdle: begin
          if (ivalid && isop) begin
            da_q    <= pMAC_WIDTH'(idata);
            sa_q    <= '0;
            port_q  <= iport;
            cnt_q   <= CntW'(1);
            state_q <= ieop ? StIdle : StCollect;
          end
        end
        StCollect: begin
          if (ivalid) begin
            if (isop) begin
              da_q    <= pMAC_WIDTH'(idata);
              sa_q    <= '0;
              port_q  <= iport;
              cnt_q   <= CntW'(1);
              state_q <= ieop ? StIdle : StCollect;
            end else begin
              if (cnt_q < CntW'(MacBytes)) begin
                da_q <= {da_q[pMAC_WIDTH-pDATA_WIDTH-1:0], idata};
              end else begin
                sa_q <= {sa_q[pMAC_WIDTH-pDATA_WIDTH-1:0], idata};
              end
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CntW'(LastByte)) begin
                state_q <= StLookup;
                obusy   <= 1'b1;
                if (!da_q[GroupBit]) begin
                  omem_re   <= 1'b1;
                  omem_addr <= da_q[pSIZE_OUT-1:0];
                end
              end else if (ieop) begin
                state_q <= StIdle;
              end
            end
          end
        end
        StLookup: begin
          state_q <= StLearn;
          if (!sa_q[GroupBit]) begin
            omem_we    <= 1'b1;
            omem_addr  <= sa_q[pSIZE_OUT-1:0];
            omem_wdata <= {1'b1, sa_q, port_q};
          end
        end
        StLearn: begin
          state_q    <= StResult;
          ores_valid <= 1'b1;
          ohit       <= hit;
          odst_port  <= hit ? imem_rdata[pPORT_W-1:0] : '0;
        end
        StResult: begin
          state_q <= StIdle;
          obusy   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          obusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_table_ctrl.sv
// Directed bench for mac_table_ctrl with a registered single-port table model.
module tb_mac_table_ctrl;

  logic        iclk;
  logic        irst;
  logic [7:0]  idata;
  logic        ivalid;
  logic        isop;
  logic        ieop;
  logic [2:0]  iport;
  logic [13:0] omem_addr;
  logic        omem_re;
  logic        omem_we;
  logic [51:0] omem_wdata;
  logic [51:0] imem_rdata;
  logic        ores_valid;
  logic        ohit;
  logic [2:0]  odst_port;
  logic        obusy;
  logic        ooverrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [51:0] mem [16384];

  mac_table_ctrl dut (
    .iclk       (iclk),
    .irst       (irst),
    .idata      (idata),
    .ivalid     (ivalid),
    .isop       (isop),
    .ieop       (ieop),
    .iport      (iport),
    .omem_addr  (omem_addr),
    .omem_re    (omem_re),
    .omem_we    (omem_we),
    .omem_wdata (omem_wdata),
    .imem_rdata (imem_rdata),
    .ores_valid (ores_valid),
    .ohit       (ohit),
    .odst_port  (odst_port),
    .obusy      (obusy),
    .ooverrun   (ooverrun)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(posedge iclk) begin
    if (omem_we) mem[omem_addr] <= omem_wdata;
    if (omem_re) imem_rdata <= mem[omem_addr];
  end

  task automatic chk(input string tag, input string field, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  task automatic idle_in();
    ivalid = 1'b0;
    isop   = 1'b0;
    ieop   = 1'b0;
    idata  = 8'h00;
  endtask

  task automatic drive_byte(input logic [95:0] hdr, input int k, input logic sop,
                            input logic eop);
    @(negedge iclk);
    ivalid = 1'b1;
    isop   = sop;
    ieop   = eop;
    idata  = hdr[95-8*k -: 8];
  endtask

  task automatic send_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [2:0] port);
    logic [95:0] hdr;
    hdr = {da, sa};
    iport = port;
    for (int k = 0; k < 12; k++) drive_byte(hdr, k, k == 0, k == 11);
  endtask

  task automatic run_frame(input string tag, input logic [47:0] da, input logic [47:0] sa,
                           input logic [2:0] port, input logic exp_re, input logic [13:0] rd_addr,
                           input logic exp_we, input logic [13:0] wr_addr,
                           input logic [51:0] wdata, input logic exp_hit,
                           input logic [2:0] exp_dport);
    send_hdr(da, sa, port);
    @(negedge iclk);  // LOOKUP
    idle_in();
    chk(tag, "lk_re", omem_re, exp_re);
    chk(tag, "lk_addr", omem_addr, exp_re ? rd_addr : 14'h0);
    chk(tag, "lk_we", omem_we, 1'b0);
    chk(tag, "lk_busy", obusy, 1'b1);
    chk(tag, "lk_resv", ores_valid, 1'b0);
    @(negedge iclk);  // LEARN
    chk(tag, "ln_re", omem_re, 1'b0);
    chk(tag, "ln_we", omem_we, exp_we);
    chk(tag, "ln_addr", omem_addr, exp_we ? wr_addr : 14'h0);
    if (exp_we) chk(tag, "ln_wdata", omem_wdata, wdata);
    chk(tag, "ln_resv", ores_valid, 1'b0);
    @(negedge iclk);  // RESULT
    chk(tag, "rs_resv", ores_valid, 1'b1);
    chk(tag, "rs_hit", ohit, exp_hit);
    chk(tag, "rs_dport", odst_port, exp_dport);
    chk(tag, "rs_strobes", {omem_re, omem_we}, 2'b00);
    chk(tag, "rs_addr", omem_addr, 14'h0);
    chk(tag, "rs_busy", obusy, 1'b1);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, "re", omem_re, 1'b0);
    chk(tag, "we", omem_we, 1'b0);
    chk(tag, "resv", ores_valid, 1'b0);
  endtask

  initial begin
    logic [95:0] hdr;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    imem_rdata = '0;
    iport = 3'd0;
    idle_in();
    irst = 1'b1;
    repeat (3) @(negedge iclk);
    chk("reset", "addr", omem_addr, 14'h0);
    chk("reset", "re", omem_re, 1'b0);
    chk("reset", "we", omem_we, 1'b0);
    chk("reset", "wdata", omem_wdata, 52'h0);
    chk("reset", "resv", ores_valid, 1'b0);
    chk("reset", "hit", ohit, 1'b0);
    chk("reset", "dport", odst_port, 3'd0);
    chk("reset", "busy", obusy, 1'b0);
    chk("reset", "ovr", ooverrun, 1'b0);
    irst = 1'b0;

    // Learn with broadcast DA, then hit on the learned address.
    run_frame("f1", 48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 3'd2,
              1'b0, 14'h0, 1'b1, 14'h0455, {1'b1, 48'h0011_2233_4455, 3'd2}, 1'b0, 3'd0);
    run_frame("f2", 48'h0011_2233_4455, 48'h0200_0000_0007, 3'd1,
              1'b1, 14'h0455, 1'b1, 14'h0007, {1'b1, 48'h0200_0000_0007, 3'd1}, 1'b1, 3'd2);
    // Same index, different MAC: miss.
    run_frame("f3", 48'hAABB_CCDD_0455, 48'h0200_0000_0008, 3'd3,
              1'b1, 14'h0455, 1'b1, 14'h0008, {1'b1, 48'h0200_0000_0008, 3'd3}, 1'b0, 3'd0);
    // Collision overwrite from port 5.
    run_frame("f4", 48'h0200_0000_0007, 48'hAABB_CCDD_0455, 3'd5,
              1'b1, 14'h0007, 1'b1, 14'h0455, {1'b1, 48'hAABB_CCDD_0455, 3'd5}, 1'b1, 3'd1);
    run_frame("f5", 48'h0011_2233_4455, 48'h0200_0000_0009, 3'd0,
              1'b1, 14'h0455, 1'b1, 14'h0009, {1'b1, 48'h0200_0000_0009, 3'd0}, 1'b0, 3'd0);
    // Multicast SA is not learned.
    run_frame("f6", 48'hAABB_CCDD_0455, 48'h0100_5E00_0001, 3'd4,
              1'b1, 14'h0455, 1'b0, 14'h0, 52'h0, 1'b1, 3'd5);
    @(negedge iclk);
    chk("f6", "idle_busy", obusy, 1'b0);

    // Runt: 8 bytes, ieop on byte 7.
    hdr = {48'h0200_0000_0007, 48'h0200_0000_0010};
    iport = 3'd2;
    for (int k = 0; k < 8; k++) drive_byte(hdr, k, k == 0, k == 7);
    for (int c = 0; c < 5; c++) begin
      @(negedge iclk);
      idle_in();
      chk_quiet("runt");
      chk("runt", "busy", obusy, 1'b0);
    end
    run_frame("f7", 48'h0200_0000_0008, 48'h0200_0000_000A, 3'd6,
              1'b1, 14'h0008, 1'b1, 14'h000A, {1'b1, 48'h0200_0000_000A, 3'd6}, 1'b1, 3'd3);

    // Overrun: second frame's isop lands in LEARN.
    send_hdr(48'h0200_0000_000A, 48'h0200_0000_000B, 3'd7);
    @(negedge iclk);
    idle_in();
    chk("ovr", "lk_re", omem_re, 1'b1);
    chk("ovr", "lk_addr", omem_addr, 14'h000A);
    hdr = {48'h0200_0000_0007, 48'h0200_0000_000E};
    iport = 3'd1;
    drive_byte(hdr, 0, 1'b1, 1'b0);
    chk("ovr", "ln_we", omem_we, 1'b1);
    chk("ovr", "ln_addr", omem_addr, 14'h000B);
    drive_byte(hdr, 1, 1'b0, 1'b0);
    chk("ovr", "rs_resv", ores_valid, 1'b1);
    chk("ovr", "rs_hit", ohit, 1'b1);
    chk("ovr", "rs_dport", odst_port, 3'd6);
    chk("ovr", "pulse", ooverrun, 1'b1);
    for (int k = 2; k < 12; k++) begin
      drive_byte(hdr, k, 1'b0, k == 11);
      chk_quiet("ovr_drop");
      chk("ovr_drop", "pulse", ooverrun, 1'b0);
    end
    @(negedge iclk);
    idle_in();
    chk_quiet("ovr_drop");
    chk("ovr_drop", "busy", obusy, 1'b0);
    // Dropped frame's SA must not have been learned.
    run_frame("f9", 48'h0200_0000_000E, 48'h0200_0000_000F, 3'd3,
              1'b1, 14'h000E, 1'b1, 14'h000F, {1'b1, 48'h0200_0000_000F, 3'd3}, 1'b0, 3'd0);

    // Reset in the LOOKUP cycle.
    send_hdr(48'h0011_2233_4455, 48'h0200_0000_000C, 3'd2);
    @(negedge iclk);
    idle_in();
    chk("rst", "lk_re", omem_re, 1'b1);
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    chk("rst", "addr", omem_addr, 14'h0);
    chk("rst", "re", omem_re, 1'b0);
    chk("rst", "we", omem_we, 1'b0);
    chk("rst", "resv", ores_valid, 1'b0);
    chk("rst", "busy", obusy, 1'b0);
    chk("rst", "hit", ohit, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge iclk);
      chk_quiet("rst_after");
    end
    run_frame("f11", 48'h0200_0000_000C, 48'h0200_0000_000D, 3'd1,
              1'b1, 14'h000C, 1'b1, 14'h000D, {1'b1, 48'h0200_0000_000D, 3'd1}, 1'b0, 3'd0);
    @(negedge iclk);
    chk("f11", "idle_busy", obusy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
